// File: rtl/stack_sequencer_pkg.sv
// Shared types and constants for the stack push/pop sequencer.
package stack_sequencer_pkg;

  typedef enum logic [1:0] {IDLE, POP, PUSH, FIN} stack_state_e;

  localparam logic [3:0] STACK_ITEM_SP         = 4'd4;
  localparam logic [3:0] STACK_ITEM_SP_DISCARD = 4'd5;

  // Pre-decoder item masks; bit index doubles as register file select.
  localparam logic [15:0] STACK_AW         = 16'h0001;
  localparam logic [15:0] STACK_CW         = 16'h0002;
  localparam logic [15:0] STACK_DW         = 16'h0004;
  localparam logic [15:0] STACK_BW         = 16'h0008;
  localparam logic [15:0] STACK_SP         = 16'h0010;
  localparam logic [15:0] STACK_SP_DISCARD = 16'h0020;
  localparam logic [15:0] STACK_BP         = 16'h0040;
  localparam logic [15:0] STACK_IX         = 16'h0080;
  localparam logic [15:0] STACK_IY         = 16'h0100;
  localparam logic [15:0] STACK_PSW        = 16'h0400;
  localparam logic [15:0] STACK_PS         = 16'h0800;
  localparam logic [15:0] STACK_PC         = 16'h4000;
  localparam logic [15:0] STACK_OPERAND    = 16'h8000;

  function automatic logic [31:0] stack_phys(input logic [15:0] seg, input logic [15:0] off);
    return {12'h000, seg, 4'h0} + {16'h0000, off};
  endfunction

endpackage

// File: rtl/stack_sequencer_if.sv
// Memory-side bus between the stack sequencer (master) and the bus interface unit (slave).
interface stack_sequencer_if #(parameter int ADDR_W = 20);
  logic              bus_req;
  logic              bus_wr;
  logic [ADDR_W-1:0] bus_addr;
  logic [1:0]        bus_be;
  logic [15:0]       bus_wdata;
  logic              bus_ack;
  logic [15:0]       bus_rdata;

  modport master (output bus_req, bus_wr, bus_addr, bus_be, bus_wdata,
                  input  bus_ack, bus_rdata);
  modport slave  (input  bus_req, bus_wr, bus_addr, bus_be, bus_wdata,
                  output bus_ack, bus_rdata);
endinterface

// File: rtl/stack_sequencer_mask_pick.sv
// 16-bit priority encoder: index of the lowest (HIGHEST=0) or highest (HIGHEST=1) set bit.
module stack_mask_pick #(
  parameter bit HIGHEST = 1'b0
) (
  input  logic [15:0] mask_i,
  output logic [3:0]  idx_o,
  output logic        any_o
);

  always_comb begin
    idx_o = '0;
    if (HIGHEST) begin
      for (int i = 0; i < 16; i++) if (mask_i[i]) idx_o = 4'(i);
    end else begin
      for (int i = 15; i >= 0; i--) if (mask_i[i]) idx_o = 4'(i);
    end
  end

  assign any_o = |mask_i;

endmodule

// File: rtl/stack_sequencer.sv
// Runs pop then push item masks as SS:SP memory cycles.
// Optional macro STACK_SEQ_ODD_SPLIT_EN splits odd-address items into two byte cycles.
module stack_sequencer
  import stack_sequencer_pkg::*;
#(
  parameter int ADDR_W           = 20,
  parameter bit SP_PUSH_ORIGINAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] push_mask,
  input  logic [15:0] pop_mask,
  input  logic [15:0] sp_in,
  input  logic [15:0] ss,
  output logic        busy,
  output logic        done,
  output logic [3:0]  item,
  input  logic [15:0] reg_rdata,
  output logic        wr_en,
  output logic [3:0]  wr_item,
  output logic [15:0] wr_data,
  output logic [15:0] sp_out,
  output logic        sp_we,
  stack_sequencer_if.master bus
);

  stack_state_e state_q, state_d;
  logic [15:0]  push_q, push_d, pop_q, pop_d;
  logic [15:0]  sp_q, sp_d, sp_orig_q, sp_orig_d, ss_q, ss_d;
  logic         half_q, half_d;
  logic [7:0]   lo_byte_q, lo_byte_d;

  logic [3:0]        pop_idx, push_idx;
  logic              pop_any, push_any;
  logic [15:0]       item_sp, push_word, pop_word, pop_left, push_left;
  logic [31:0]       phys;
  logic [ADDR_W-1:0] word_addr, addr_c;
  logic              split, item_done, req_c, wr_c;
  logic [1:0]        be_c;
  logic [15:0]       wdata_c;

  stack_mask_pick #(.HIGHEST(1'b1)) u_pop_pick  (.mask_i(pop_q),  .idx_o(pop_idx),  .any_o(pop_any));
  stack_mask_pick #(.HIGHEST(1'b0)) u_push_pick (.mask_i(push_q), .idx_o(push_idx), .any_o(push_any));

  // A push item addresses the already-decremented sp; sp_q itself only moves on the final ack.
  assign item_sp   = (state_q == PUSH) ? sp_q - 16'd2 : sp_q;
  assign phys      = stack_phys(ss_q, item_sp);
  assign word_addr = phys[ADDR_W-1:0];
  assign push_word = (push_idx == STACK_ITEM_SP) ? (SP_PUSH_ORIGINAL ? sp_orig_q : sp_q - 16'd2)
                                                 : reg_rdata;
  assign pop_word  = split ? {bus.bus_rdata[7:0], lo_byte_q} : bus.bus_rdata;
  assign pop_left  = pop_q & ~(16'd1 << pop_idx);
  assign push_left = push_q & ~(16'd1 << push_idx);

`ifdef STACK_SEQ_ODD_SPLIT_EN
  assign split = word_addr[0];
`else
  assign split = 1'b0;
`endif

  assign item_done = bus.bus_ack && (!split || half_q);

  always_comb begin
    state_d   = state_q;
    push_d    = push_q;
    pop_d     = pop_q;
    sp_d      = sp_q;
    sp_orig_d = sp_orig_q;
    ss_d      = ss_q;
    half_d    = half_q;
    lo_byte_d = lo_byte_q;
    req_c     = 1'b0;
    wr_c      = 1'b0;
    addr_c    = '0;
    be_c      = 2'b11;
    wdata_c   = '0;
    item      = '0;
    wr_en     = 1'b0;
    wr_item   = '0;
    wr_data   = '0;
    done      = 1'b0;
    sp_we     = 1'b0;
    sp_out    = '0;

    if (state_q == POP || state_q == PUSH) begin
      req_c  = 1'b1;
      addr_c = word_addr;
      if (split) begin
        be_c   = half_q ? 2'b01 : 2'b10;
        addr_c = half_q ? word_addr + ADDR_W'(1) : word_addr;
      end
      if (bus.bus_ack && split && !half_q) half_d = 1'b1;
      if (item_done) half_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          push_d    = push_mask;
          pop_d     = pop_mask;
          sp_d      = sp_in;
          sp_orig_d = sp_in;
          ss_d      = ss;
          half_d    = 1'b0;
          state_d   = (pop_mask != '0) ? POP : ((push_mask != '0) ? PUSH : FIN);
        end
      end
      POP: begin
        if (!pop_any) begin
          req_c   = 1'b0;
          state_d = push_any ? PUSH : FIN;
        end else begin
          if (bus.bus_ack && split && !half_q) lo_byte_d = bus.bus_rdata[15:8];
          if (item_done) begin
            wr_en   = (pop_idx != STACK_ITEM_SP_DISCARD);
            wr_item = pop_idx;
            wr_data = pop_word;
            pop_d   = pop_left;
            sp_d    = (pop_idx == STACK_ITEM_SP) ? pop_word : sp_q + 16'd2;
            if (pop_left == '0) state_d = push_any ? PUSH : FIN;
          end
        end
      end
      PUSH: begin
        item = push_idx;
        wr_c = 1'b1;
        if (!split) wdata_c = push_word;
        else        wdata_c = half_q ? {8'h00, push_word[15:8]} : {push_word[7:0], 8'h00};
        if (!push_any) begin
          req_c   = 1'b0;
          wr_c    = 1'b0;
          state_d = FIN;
        end else if (item_done) begin
          push_d = push_left;
          sp_d   = sp_q - 16'd2;
          if (push_left == '0) state_d = FIN;
        end
      end
      FIN: begin
        done    = 1'b1;
        sp_we   = 1'b1;
        sp_out  = sp_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      push_q    <= '0;
      pop_q     <= '0;
      sp_q      <= '0;
      sp_orig_q <= '0;
      ss_q      <= '0;
      half_q    <= 1'b0;
      lo_byte_q <= '0;
    end else begin
      state_q   <= state_d;
      push_q    <= push_d;
      pop_q     <= pop_d;
      sp_q      <= sp_d;
      sp_orig_q <= sp_orig_d;
      ss_q      <= ss_d;
      half_q    <= half_d;
      lo_byte_q <= lo_byte_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign bus.bus_req   = req_c;
  assign bus.bus_wr    = wr_c;
  assign bus.bus_addr  = addr_c;
  assign bus.bus_be    = be_c;
  assign bus.bus_wdata = wdata_c;

endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
- Executes the stack push/pop bit masks that the pre-decoder emits (STACK_AW … STACK_OPERAND) as a sequence of SS:SP memory cycles.
- Push writes register values to memory. Pop reads memory back into registers.
- Sits between the execute unit, the register file and the bus interface unit.
- Used by PUSH/POP, PUSH ALL/POP ALL, CALL/RET, interrupt entry and RETI.

Parameters:
ADDR_W, 20, physical address width; address = ((ss<<4) + sp) mod 2^ADDR_W
SP_PUSH_ORIGINAL, 1, 1: a STACK_SP push writes SP as latched at start; 0: writes SP already decremented for that item

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; ignored while busy
push_mask  in  16  STACK_* items to push
pop_mask  in  16  STACK_* items to pop
sp_in  in  16  SP at start
ss  in  16  stack segment, held stable while busy
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
item  out  4  bit index of current push item (register file read select)
reg_rdata  in  16  register value for item, combinational from register file
wr_en  out  1  pop write-back strobe
wr_item  out  4  bit index of popped item
wr_data  out  16  popped value
sp_out  out  16  final SP
sp_we  out  1  sp_out valid, same cycle as done
bus_req  out  1  memory request
bus_wr  out  1  1 = write
bus_addr  out  ADDR_W  physical address
bus_be  out  2  byte lanes {hi,lo}
bus_wdata  out  16  write data
bus_ack  in  1  transfer complete this cycle
bus_rdata  in  16  read data, valid with bus_ack

Behaviour:
- Reset (async, reset_n=0): state IDLE.
  - busy, done, wr_en, sp_we, bus_req and bus_wr are 0.
  - item, wr_item, wr_data, sp_out, bus_addr and bus_wdata are 0.
  - bus_be = 2'b11.
  - Reset mid-operation abandons the operation. No further wr_en or sp_we is produced.
- States: IDLE, POP, PUSH, FIN.
- IDLE:
  - start latches both masks, sp_in into working sp, and ss; sets busy.
  - Next state: POP if pop_mask≠0, else PUSH if push_mask≠0, else FIN.
- Ordering:
  - All pops complete before any push.
  - Pops run highest set bit first.
  - Pushes run lowest set bit first (AW…IY, then PSW, PS, PC, OPERAND).
- PUSH item:
  - Working sp is decremented by 2 on entry to the item.
  - Drives bus_req=1, bus_wr=1, bus_addr from the new sp, bus_wdata = reg_rdata (for the STACK_SP item, the SP value per SP_PUSH_ORIGINAL).
  - Holds until bus_ack, then clears the bit.
- POP item:
  - Drives bus_req=1, bus_wr=0, bus_addr from the current sp.
  - On the bus_ack cycle: wr_en=1, wr_item = bit index, wr_data = bus_rdata; sp += 2.
  - STACK_SP_DISCARD: read performed, wr_en suppressed.
  - STACK_SP: popped value becomes the working sp for subsequent items.
- Handshake:
  - bus_addr, bus_wdata and bus_be are stable from assertion of bus_req until the cycle bus_ack=1.
  - An ack in the same cycle as request assertion is legal: throughput is 1 item/cycle.
  - bus_req drops for 0 cycles between items. The next item is presented the cycle after ack.
- FIN: done=1, sp_we=1, sp_out = working sp for one cycle; busy drops and the state returns to IDLE.
  - Empty masks give done 1 cycle after start, no bus_req, and sp_we=1 with sp_out = sp_in.
- Arithmetic: sp wraps mod 2^16; address wraps mod 2^ADDR_W.
- Without the optional feature, bus_be is always 2'b11 and odd addresses are issued as a single word cycle.

Optional Feature:
- Macro: STACK_SEQ_ODD_SPLIT_EN.
- When defined, an odd physical address splits each item into two cycles:
  - Cycle 1: addr, bus_be=2'b10, low byte on bus_wdata[15:8] (pop takes low byte from bus_rdata[15:8]).
  - Cycle 2: addr+1, bus_be=2'b01, high byte on [7:0].
- Pop asserts wr_en only after the second ack, with the assembled word.
- When undefined: no split; behaviour as above.

Decomposition:
- Package types additions:
  - stack_state_e {IDLE, POP, PUSH, FIN}.
  - STACK_ITEM_SP=4, STACK_ITEM_SP_DISCARD=5 index constants.
  - Existing STACK_* masks are reused unchanged.
- Sub-module stack_mask_pick: 16-bit priority encoder, parameter selecting lowest/highest set bit, outputs index and any-set.

Test Plan:
- PUSH ALL: push_mask=0x01DF, sp_in=0x0100, ss=0x2000.
  - Writes at 0x200FE down to 0x200F0, items 0,1,2,3,4,6,7,8.
  - Item 4 data = 0x0100; sp_out = 0x00F0.
- POP ALL: pop_mask=0x01EF, sp_in=0x00F0.
  - Reads 0x200F0 up to 0x200FE; wr_item sequence 8,7,6,3,2,1,0; no wr_en for item 5; sp_out = 0x0100.
- Interrupt: push_mask=0x4C00, sp_in=0x0000, ss=0x2000.
  - Addresses 0x2FFFE (PSW), 0x2FFFC (PS), 0x2FFFA (PC); sp_out = 0xFFFA.
- bus_ack held low 3 cycles per item, with start pulsed while busy.
  - bus_req/addr/wdata stable throughout; second start ignored; exactly one done.
- Empty masks: done 1 cycle after start, no bus_req, sp_out = sp_in.
- Reset mid-operation: reset_n=0 mid-pop → all outputs reset values immediately, no wr_en or done afterward.
  - With STACK_SEQ_ODD_SPLIT_EN: sp_in=0x0101 push → cycles be=10 @0x200FF, then be=01 @0x20100.
